fadd_align_stage: RTL and testbench
===================================

// Module: fadd_align_stage
// PURPOSE
//  Pre-add alignment stage of the single-precision FP adder; feeds the 33-bit carry-lookahead adder.
//  Unpacks two IEEE-754 binary32 operands and selects the larger magnitude. Right-shifts the smaller
//  mantissa with sticky collection, conditionally inverts it for effective subtraction, and presents
//  33-bit adder operands plus carry-in.
//  Two-stage pipeline with valid/ready flow control; downstream is the adder and the normalise/round logic.
// PARAMETERS
//  EXP_W  8   exponent width (fixed for binary32)
//  MAN_W  23  stored fraction width
//  EXT_W  8   extension bits below mantissa LSB; bit 0 of the extension is the sticky bit
//  (derived) OP_W = 1+1+MAN_W+EXT_W = 33: {headroom, hidden, fraction, extension}
// PORTS
//  clk              in   1   clock, rising edge
//  rst_n            in   1   asynchronous active-low reset
//  in_valid         in   1   input operands valid
//  in_ready         out  1   stage accepts input this cycle
//  in_a, in_b       in   32  binary32 operands
//  in_sub           in   1   1 = compute a-b, 0 = a+b
//  out_valid        out  1   output bundle valid
//  out_ready        in   1   downstream accepts output
//  out_a            out  33  larger-magnitude operand, aligned
//  out_b            out  33  smaller operand, shifted; one's-complemented when out_sub=1
//  out_cin          out  1   adder carry-in (= out_sub)
//  out_exp          out  8   exponent of larger operand (denormal reported as 1)
//  out_sign         out  1   result sign (sign of larger operand after in_sub applied to b)
//  out_sub          out  1   effective subtraction flag
//  out_class        out  2   00 finite, 01 infinity, 10 NaN
//  out_special      out  32  result word when out_class!=00, else 0
// BEHAVIOUR
//  Reset (async, rst_n=0): all valid flags 0; every output register 0; in_ready reflects empty pipe (=1).
//  Stage 1 (S1), unpack, on accept (in_valid & in_ready):
//   - hidden bit = (exp!=0); exponent of a denormal is treated as 1; sign_b' = sign_b ^ in_sub.
//   - Magnitude compare on {exp,fraction}; on tie a is "big". eff_sub = sign_a ^ sign_b'.
//   - Register big/small fields, d = exp_big - exp_small, sign = sign of big, class, special word.
//  Stage 2 (S2), align:
//   - X = {1'b0, hid_s, frac_s, EXT_W'b0}; Y = X >> min(d,33).
//   - Y[0] |= OR of every bit shifted out below bit 0; d>=33 yields Y = {32'b0, (X!=0)}.
//   - out_a = {1'b0, hid_b, frac_b, EXT_W'b0}; out_b = eff_sub ? ~Y : Y; out_cin = eff_sub.
//  Specials: either input NaN, or Inf-Inf with eff_sub -> class 10, special 32'h7FC00000.
//   Else any Inf -> class 01, special {sign_of_inf, 8'hFF, 23'b0}.
//   Data fields remain computed but are don't-care for non-finite classes.
//  Flow control: S2 loads when !out_valid | out_ready; S1 loads when !s1_valid | S2 loads.
//   in_ready = !s1_valid | !out_valid | out_ready (combinational from out_ready, no other comb path).
//  Latency 2 cycles accept-to-out_valid with no stall; throughput 1/cycle; order preserved.
//  Output bundle held stable while out_valid & !out_ready; no drop, no duplication.
//  Simultaneous accept and emit in one cycle is legal and keeps full throughput.
//  Reset mid-operation discards all in-flight operands; first accept after release is normal.
// TESTING
//  1. a=b=32'h3F800000, sub=0 -> out_a=out_b=33'h0_8000_0000, cin=0, exp=127, sign=0, class=00, 2 cycles later.
//  2. a=b=32'h3F800000, sub=1 -> out_a=33'h0_8000_0000, out_b=33'h1_7FFF_FFFF, cin=1, sub=1.
//  3. a=32'h3F800000, b=32'h2B800000 (2^-40), sub=0 -> d=40, out_b=33'h0_0000_0001 (sticky only).
//  4. a=32'h40000000, b=32'hC0400000, sub=0 -> big=b, sign=1, sub=1, exp=128, out_b=~33'h0_8000_0000.
//  5. Stream 4 ops with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted; all 4 emerge in order.
//  6. a=32'h7F800000, b=32'h7F800000, sub=1 -> class=10, special=32'h7FC00000; rst_n pulse mid-stream -> out_valid=0.

Source files
------------

// File: rtl/fadd_align_stage.sv
// Pre-add alignment for the binary32 adder: unpack and order operands (S1), then shift the
// smaller mantissa with sticky collection and invert it for effective subtraction (S2).
module fadd_align_stage #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int EXT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [EXP_W+MAN_W:0]       in_a_i,
    input  logic [EXP_W+MAN_W:0]       in_b_i,
    input  logic                       in_sub_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [MAN_W+EXT_W+1:0]     out_a_o,
    output logic [MAN_W+EXT_W+1:0]     out_b_o,
    output logic                       out_cin_o,
    output logic [EXP_W-1:0]           out_exp_o,
    output logic                       out_sign_o,
    output logic                       out_sub_o,
    output logic [1:0]                 out_class_o,
    output logic [EXP_W+MAN_W:0]       out_special_o
);
    localparam int OP_W   = 1 + 1 + MAN_W + EXT_W;
    localparam int WORD_W = 1 + EXP_W + MAN_W;
    localparam int SH_W   = $clog2(OP_W + 1);
    localparam logic [1:0] CLS_FIN = 2'b00;
    localparam logic [1:0] CLS_INF = 2'b01;
    localparam logic [1:0] CLS_NAN = 2'b10;
    localparam logic [WORD_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic              s1_valid_q;
    logic              s1_hid_b_q, s1_hid_b_d, s1_hid_s_q, s1_hid_s_d;
    logic [MAN_W-1:0]  s1_frac_b_q, s1_frac_b_d, s1_frac_s_q, s1_frac_s_d;
    logic [EXP_W-1:0]  s1_dist_q, s1_dist_d, s1_exp_q, s1_exp_d;
    logic              s1_sign_q, s1_sign_d, s1_sub_q, s1_sub_d;
    logic [1:0]        s1_class_q, s1_class_d;
    logic [WORD_W-1:0] s1_special_q, s1_special_d;

    logic              out_valid_q;
    logic [OP_W-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;
    logic [EXP_W-1:0]  out_exp_q;
    logic              out_sign_q, out_sub_q;
    logic [1:0]        out_class_q;
    logic [WORD_W-1:0] out_special_q;

    logic s2_load, s1_load, s1_accept;

    assign s2_load    = !out_valid_q || out_ready_i;
    assign s1_load    = !s1_valid_q || s2_load;
    assign s1_accept  = in_valid_i && s1_load;
    assign in_ready_o = s1_load;

    logic             sign_a, sign_b, a_big;
    logic [EXP_W-1:0] exp_a, exp_b, eexp_a, eexp_b;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic             nan_a, nan_b, inf_a, inf_b;

    assign sign_a = in_a_i[WORD_W-1];
    assign sign_b = in_b_i[WORD_W-1] ^ in_sub_i;
    assign exp_a  = in_a_i[WORD_W-2:MAN_W];
    assign exp_b  = in_b_i[WORD_W-2:MAN_W];
    assign frac_a = in_a_i[MAN_W-1:0];
    assign frac_b = in_b_i[MAN_W-1:0];
    assign eexp_a = (exp_a == '0) ? EXP_W'(1) : exp_a;
    assign eexp_b = (exp_b == '0) ? EXP_W'(1) : exp_b;
    assign nan_a  = (exp_a == '1) && (frac_a != '0);
    assign nan_b  = (exp_b == '1) && (frac_b != '0);
    assign inf_a  = (exp_a == '1) && (frac_a == '0);
    assign inf_b  = (exp_b == '1) && (frac_b == '0);
    // Raw {exp,fraction} orders magnitudes correctly, denormals included; ties keep a as big.
    assign a_big  = in_a_i[WORD_W-2:0] >= in_b_i[WORD_W-2:0];

    always_comb begin
        s1_hid_b_d   = a_big ? (exp_a != '0) : (exp_b != '0);
        s1_hid_s_d   = a_big ? (exp_b != '0) : (exp_a != '0);
        s1_frac_b_d  = a_big ? frac_a : frac_b;
        s1_frac_s_d  = a_big ? frac_b : frac_a;
        s1_exp_d     = a_big ? eexp_a : eexp_b;
        s1_dist_d    = a_big ? (eexp_a - eexp_b) : (eexp_b - eexp_a);
        s1_sign_d    = a_big ? sign_a : sign_b;
        s1_sub_d     = sign_a ^ sign_b;
        s1_class_d   = CLS_FIN;
        s1_special_d = '0;
        if (nan_a || nan_b || (inf_a && inf_b && s1_sub_d)) begin
            s1_class_d   = CLS_NAN;
            s1_special_d = QNAN;
        end else if (inf_a || inf_b) begin
            s1_class_d   = CLS_INF;
            s1_special_d = {inf_a ? sign_a : sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    logic [OP_W-1:0] x_sml, y_sml;
    logic [SH_W-1:0] shamt;
    logic            lost;

    always_comb begin
        x_sml   = {1'b0, s1_hid_s_q, s1_frac_s_q, {EXT_W{1'b0}}};
        shamt   = s1_dist_q[SH_W-1:0];
        y_sml   = '0;
        lost    = 1'b0;
        if (s1_dist_q >= EXP_W'(OP_W)) begin
            y_sml[0] = |x_sml;
        end else begin
            y_sml    = x_sml >> shamt;
            lost     = |(x_sml & ~({OP_W{1'b1}} << shamt));
            y_sml[0] = y_sml[0] | lost;
        end
        out_a_d = {1'b0, s1_hid_b_q, s1_frac_b_q, {EXT_W{1'b0}}};
        out_b_d = s1_sub_q ? ~y_sml : y_sml;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_hid_b_q   <= 1'b0;
            s1_hid_s_q   <= 1'b0;
            s1_frac_b_q  <= '0;
            s1_frac_s_q  <= '0;
            s1_dist_q    <= '0;
            s1_exp_q     <= '0;
            s1_sign_q    <= 1'b0;
            s1_sub_q     <= 1'b0;
            s1_class_q   <= CLS_FIN;
            s1_special_q <= '0;
        end else begin
            if (s1_load) s1_valid_q <= in_valid_i;
            if (s1_accept) begin
                s1_hid_b_q   <= s1_hid_b_d;
                s1_hid_s_q   <= s1_hid_s_d;
                s1_frac_b_q  <= s1_frac_b_d;
                s1_frac_s_q  <= s1_frac_s_d;
                s1_dist_q    <= s1_dist_d;
                s1_exp_q     <= s1_exp_d;
                s1_sign_q    <= s1_sign_d;
                s1_sub_q     <= s1_sub_d;
                s1_class_q   <= s1_class_d;
                s1_special_q <= s1_special_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_exp_q     <= '0;
            out_sign_q    <= 1'b0;
            out_sub_q     <= 1'b0;
            out_class_q   <= CLS_FIN;
            out_special_q <= '0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_a_q       <= out_a_d;
                out_b_q       <= out_b_d;
                out_exp_q     <= s1_exp_q;
                out_sign_q    <= s1_sign_q;
                out_sub_q     <= s1_sub_q;
                out_class_q   <= s1_class_q;
                out_special_q <= s1_special_q;
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_a_o       = out_a_q;
    assign out_b_o       = out_b_q;
    assign out_cin_o     = out_sub_q;
    assign out_exp_o     = out_exp_q;
    assign out_sign_o    = out_sign_q;
    assign out_sub_o     = out_sub_q;
    assign out_class_o   = out_class_q;
    assign out_special_o = out_special_q;
endmodule

// File: tb/tb_fadd_align_stage.sv
// Bench for fadd_align_stage: directed cases plus randomized valid/ready traffic scored
// against an arithmetic reference model.
module tb_fadd_align_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_sub = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [32:0] out_a, out_b;
    logic        out_cin, out_sign, out_sub;
    logic [7:0]  out_exp;
    logic [1:0]  out_class;
    logic [31:0] out_special;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [32:0] a, b;
        logic        cin, sign, sub;
        logic [7:0]  ex;
        logic [1:0]  cls;
        logic [31:0] spec;
    } tb_exp_t;

    tb_exp_t q[$];

    fadd_align_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .in_sub_i(in_sub),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_a_o(out_a), .out_b_o(out_b), .out_cin_o(out_cin),
        .out_exp_o(out_exp), .out_sign_o(out_sign), .out_sub_o(out_sub),
        .out_class_o(out_class), .out_special_o(out_special)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic tb_exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        tb_exp_t r;
        logic sa, sb, eff, a_big, nan_a, nan_b, inf_a, inf_b;
        int ea, eb, ebig, esml, d;
        longint ma, mb, mbig, msml, x, y, p, qq, rm;
        sa = a[31];
        sb = b[31] ^ sub;
        eff = sa ^ sb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (ea != 0 ? 64'd8388608 : 64'd0) + longint'(a[22:0]);
        mb = (eb != 0 ? 64'd8388608 : 64'd0) + longint'(b[22:0]);
        a_big = longint'(a[30:0]) >= longint'(b[30:0]);
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        mbig = a_big ? ma : mb;
        msml = a_big ? mb : ma;
        ebig = a_big ? ea : eb;
        esml = a_big ? eb : ea;
        d = ebig - esml;
        x = msml * 256;
        if (d >= 33) begin
            y = (x != 0) ? 1 : 0;
        end else begin
            p = 1;
            for (int i = 0; i < d; i++) p = p * 2;
            qq = x / p;
            rm = x % p;
            y = qq;
            if (rm != 0 && (qq % 2) == 0) y = qq + 1;
        end
        r.a    = 33'(mbig * 256);
        r.b    = eff ? 33'(64'h1_FFFF_FFFF - y) : 33'(y);
        r.cin  = eff;
        r.sub  = eff;
        r.ex   = 8'(ebig);
        r.sign = a_big ? sa : sb;
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (nan_a || nan_b || (inf_a && inf_b && eff)) begin
            r.cls = 2'b10; r.spec = 32'h7FC00000;
        end else if (inf_a || inf_b) begin
            r.cls = 2'b01; r.spec = {inf_a ? sa : sb, 8'hFF, 23'h0};
        end else begin
            r.cls = 2'b00; r.spec = 32'h0;
        end
        return r;
    endfunction

    task automatic check_out();
        tb_exp_t e;
        if (q.size() == 0) begin
            chk("spurious_out", 1, 0);
        end else begin
            e = q.pop_front();
            chk("class", out_class, e.cls);
            chk("special", out_special, e.spec);
            if (e.cls == 2'b00) begin
                chk("out_a", out_a, e.a);
                chk("out_b", out_b, e.b);
                chk("cin", out_cin, e.cin);
                chk("exp", out_exp, e.ex);
                chk("sign", out_sign, e.sign);
                chk("sub", out_sub, e.sub);
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic r, output logic acc);
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_sub = s; out_ready = r;
        #1;
        if (out_valid && out_ready) check_out();
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(a, b, s));
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, a, b, s, 1'b1, acc);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        chk("drain_left", q.size(), 0);
    endtask

    function automatic logic [31:0] rand_op(input int base);
        int k, e;
        logic [22:0] f;
        k = $urandom_range(0, 19);
        f = 23'($urandom);
        e = base + int'($urandom_range(0, 90)) - 45;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        case (k)
            0: begin e = 255; f = f | 23'd1; end
            1: begin e = 255; f = '0; end
            2: e = 0;
            3: begin e = 0; f = '0; end
            default: ;
        endcase
        return {1'($urandom_range(0, 1)), 8'(e), f};
    endfunction

    logic [31:0] ops_a[4], ops_b[4];
    logic        acc;
    int          idx, sent;
    logic [31:0] ca, cb;
    logic        cs;

    initial begin
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_special", out_special, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 + 1.0 with latency check
        cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, acc);
        chk("t1_acc", acc, 1);
        chk("lat0_valid", out_valid, 0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        chk("lat1_valid", out_valid, 0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        chk("lat2_valid", out_valid, 1);
        chk("t1_out_b", out_b, 33'h0_8000_0000);
        chk("t1_exp", out_exp, 127);
        drain();

        send(32'h3F800000, 32'h3F800000, 1'b1);
        send(32'h3F800000, 32'h2B800000, 1'b0);
        send(32'h40000000, 32'hC0400000, 1'b0);
        drain();

        // four ops against a stalled output
        for (int i = 0; i < 4; i++) begin
            ops_a[i] = 32'h3F800000 + 32'(i) * 32'h00100000;
            ops_b[i] = 32'h3E000000 + 32'(i) * 32'h00080000;
        end
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, ops_a[idx], ops_b[idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("stall_in_ready", in_ready, 0);
        chk("stall_accepted", idx, 2);
        for (int c = 0; c < 20 && idx < 4; c++) begin
            cycle(1'b1, ops_a[idx], ops_b[idx], 1'b0, 1'b1, acc);
            if (acc) idx++;
        end
        chk("stall_all_sent", idx, 4);
        drain();

        // randomized traffic with random stalls
        sent = 0;
        ca = rand_op(127);
        cb = rand_op(int'(ca[30:23]));
        cs = 1'($urandom_range(0, 1));
        for (int n = 0; n < 3000 && sent < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, ca, cb, cs, $urandom_range(0, 9) < 7, acc);
            if (acc) begin
                sent++;
                ca = rand_op(int'($urandom_range(1, 254)));
                cb = ($urandom_range(0, 9) == 0) ? {1'($urandom_range(0, 1)), ca[30:0]}
                                                 : rand_op(int'(ca[30:23]));
                cs = 1'($urandom_range(0, 1));
            end
        end
        chk("rand_sent", sent, 400);
        drain();

        // Inf - Inf, then reset with operands in flight
        send(32'h7F800000, 32'h7F800000, 1'b1);
        drain();
        cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h40400000, 32'h3F000000, 1'b1, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_a", out_a, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h3F800000, 32'h3F800000, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
